// File: rtl/fpu_result_arbiter_pkg.sv
// Shared types and constants for the FPU writeback result collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_result_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 5;
  localparam int RD_W   = 5;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic [RD_W-1:0]   rd;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_arbiter_rr_arbiter.sv
// Round-robin request arbiter: first asserted req at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
// Ports: req[N] requests, ptr search start (< N), grant_idx winning index, any = |req.
module rr_arbiter #(
  parameter int N     = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W:0]   cand;

  assign any = |req;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr + k never overflows before the modulo fold
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_result_arbiter.sv
// FPU writeback collector: round-robin merge of unit results into one registered slot, plus sticky fflags.
// Latency: 1 cycle from unit handshake to valid_out; 1 result/cycle sustained.
// Backpressure: slot holds while valid_out && !ready_in; all ready_out drop to 0 in that case.
// Ports: clk/reset (sync, active-high); valid_in/ready_out/result_in/flags_in/rd_in per unit;
//        valid_out/ready_in/result_out/flags_out/rd_out/unit_out merged stream;
//        fflags_we/fflags_wdata CSR write, fflags sticky accumulator.
module fpu_result_arbiter
  import fpu_result_arbiter_pkg::*;
#(
  parameter int N_UNITS = 6,
  parameter int IDX_W   = $clog2(N_UNITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_UNITS-1:0]      valid_in,
  output logic [N_UNITS-1:0]      ready_out,
  input  logic [32*N_UNITS-1:0]   result_in,
  input  logic [5*N_UNITS-1:0]    flags_in,
  input  logic [5*N_UNITS-1:0]    rd_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [31:0]             result_out,
  output logic [4:0]              flags_out,
  output logic [4:0]              rd_out,
  output logic [IDX_W-1:0]        unit_out,
  input  logic                    fflags_we,
  input  logic [4:0]              fflags_wdata,
  output logic [4:0]              fflags
);

  logic [IDX_W-1:0] grant;
  logic             any_valid;
  logic             can_load;
  logic             load;
  logic             retire;
  fpu_result_t      granted;

  logic             valid_q,  valid_d;
  fpu_result_t      slot_q,   slot_d;
  logic [IDX_W-1:0] unit_q,   unit_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]       fflags_q, fflags_d;

  rr_arbiter #(
    .N     (N_UNITS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (valid_in),
    .ptr       (rr_ptr_q),
    .grant_idx (grant),
    .any       (any_valid)
  );

  always_comb begin
    granted.result = result_in[32*grant +: 32];
    granted.flags  = flags_in[5*grant +: 5];
    granted.rd     = rd_in[5*grant +: 5];
  end

  always_comb begin
    can_load = !valid_q || ready_in;
    load     = can_load && any_valid;
    retire   = valid_q && ready_in;

    ready_out = '0;
    if (load) begin
      ready_out[grant] = 1'b1;
    end

    valid_d  = valid_q;
    slot_d   = slot_q;
    unit_d   = unit_q;
    rr_ptr_d = rr_ptr_q;

    if (load) begin
      // Covers both the empty-slot load and the same-edge replace on retire
      valid_d  = 1'b1;
      slot_d   = granted;
      unit_d   = grant;
      rr_ptr_d = (grant == IDX_W'(N_UNITS-1)) ? '0 : grant + 1'b1;
    end else if (retire) begin
      valid_d = 1'b0;
      slot_d  = '0;
      unit_d  = '0;
    end

    // Flags join fflags only when the result actually leaves toward writeback,
    // and a CSR write never swallows a flag retiring in the same cycle.
    fflags_d = fflags_q;
    if (fflags_we) begin
      fflags_d = fflags_wdata | (retire ? slot_q.flags : 5'b0);
    end else if (retire) begin
      fflags_d = fflags_q | slot_q.flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      slot_q   <= '0;
      unit_q   <= '0;
      rr_ptr_q <= '0;
      fflags_q <= '0;
    end else begin
      valid_q  <= valid_d;
      slot_q   <= slot_d;
      unit_q   <= unit_d;
      rr_ptr_q <= rr_ptr_d;
      fflags_q <= fflags_d;
    end
  end

  assign valid_out  = valid_q;
  assign result_out = slot_q.result;
  assign flags_out  = slot_q.flags;
  assign rd_out     = slot_q.rd;
  assign unit_out   = unit_q;
  assign fflags     = fflags_q;

endmodule

// File: tb/tb_fpu_result_arbiter.sv
module tb_fpu_result_arbiter;

  localparam int N  = 6;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      valid_in;
  logic [N-1:0]      ready_out;
  logic [32*N-1:0]   result_in;
  logic [5*N-1:0]    flags_in;
  logic [5*N-1:0]    rd_in;
  logic              valid_out;
  logic              ready_in;
  logic [31:0]       result_out;
  logic [4:0]        flags_out;
  logic [4:0]        rd_out;
  logic [IW-1:0]     unit_out;
  logic              fflags_we;
  logic [4:0]        fflags_wdata;
  logic [4:0]        fflags;

  // Per-unit source data, packed onto the flat buses below
  logic [31:0] u_res [N];
  logic [4:0]  u_flg [N];
  logic [4:0]  u_rd  [N];

  always_comb begin
    result_in = '0;
    flags_in  = '0;
    rd_in     = '0;
    for (int i = 0; i < N; i++) begin
      result_in[32*i +: 32] = u_res[i];
      flags_in[5*i +: 5]    = u_flg[i];
      rd_in[5*i +: 5]       = u_rd[i];
    end
  end

  always #5 clk = ~clk;

  fpu_result_arbiter #(.N_UNITS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .result_in    (result_in),
    .flags_in     (flags_in),
    .rd_in        (rd_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .result_out   (result_out),
    .flags_out    (flags_out),
    .rd_out       (rd_out),
    .unit_out     (unit_out),
    .fflags_we    (fflags_we),
    .fflags_wdata (fflags_wdata),
    .fflags       (fflags)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the output slot, pointer and sticky flags
  bit          m_valid = 0;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_flg   = '0;
  logic [4:0]  m_rd    = '0;
  int          m_unit  = 0;
  int          m_ptr   = 0;
  logic [4:0]  m_ff    = '0;
  int          last_grant = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready_out before the edge, advance the model, check registered outputs after.
  task automatic step();
    int g;
    bit anyv, can_load, retire;
    logic [N-1:0] exp_rdy;
    logic [4:0] old_flg;
    #2;
    anyv     = (valid_in != '0);
    can_load = !m_valid || ready_in;
    retire   = m_valid && ready_in;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int u;
      u = (m_ptr + k) % N;
      if (g < 0 && valid_in[u]) g = u;
    end
    exp_rdy = '0;
    if (can_load && anyv) exp_rdy[g] = 1'b1;
    chk("ready_out", ready_out, exp_rdy);
    last_grant = (can_load && anyv) ? g : -1;

    @(posedge clk);
    old_flg = m_flg;
    if (reset) begin
      m_valid = 0; m_res = '0; m_flg = '0; m_rd = '0; m_unit = 0; m_ptr = 0; m_ff = '0;
    end else begin
      if (fflags_we) m_ff = fflags_wdata | (retire ? old_flg : 5'b0);
      else if (retire) m_ff = m_ff | old_flg;
      if (can_load && anyv) begin
        m_valid = 1; m_res = u_res[g]; m_flg = u_flg[g]; m_rd = u_rd[g];
        m_unit = g; m_ptr = (g + 1) % N;
      end else if (retire) begin
        m_valid = 0; m_res = '0; m_flg = '0; m_rd = '0;
      end
    end
    #1;
    chk("valid_out", valid_out, m_valid);
    chk("result_out", result_out, m_res);
    chk("flags_out", flags_out, m_flg);
    chk("rd_out", rd_out, m_rd);
    if (m_valid) chk("unit_out", unit_out, m_unit);
    chk("fflags", fflags, m_ff);
  endtask

  int exp_seq [6] = '{1, 3, 4, 1, 3, 4};

  initial begin
    reset = 1'b1; valid_in = '0; ready_in = 1'b0; fflags_we = 1'b0; fflags_wdata = '0;
    for (int i = 0; i < N; i++) begin
      u_res[i] = 32'h1000_0000 + i; u_flg[i] = '0; u_rd[i] = 5'(i + 8);
    end
    step(); step();
    chk("reset_valid", valid_out, 1'b0);
    chk("reset_fflags", fflags, 5'd0);
    reset = 1'b0;

    // Single unit
    u_res[0] = 32'h3f80_0000; u_rd[0] = 5'd5; valid_in = 6'b000001; ready_in = 1'b1;
    #1 chk("single_rdy", ready_out, 6'b000001);
    step();
    chk("single_res", result_out, 32'h3f80_0000);
    chk("single_rd", rd_out, 5'd5);
    chk("single_unit", unit_out, 3'd0);
    valid_in = '0;
    step();

    // Contention from pointer 0
    reset = 1'b1; step(); reset = 1'b0;
    valid_in = 6'b011010;
    for (int i = 0; i < 6; i++) begin
      #1 chk("one_hot_rdy", $countones(ready_out), 1);
      step();
      chk("rr_seq", unit_out, exp_seq[i]);
    end

    // Backpressure with unit 5 waiting
    valid_in = 6'b000100; step();
    chk("bp_load2", unit_out, 3'd2);
    valid_in = 6'b100000; ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_unit", unit_out, 3'd2);
    end
    ready_in = 1'b1; step();
    chk("bp_nobubble_unit", unit_out, 3'd5);
    chk("bp_nobubble_valid", valid_out, 1'b1);
    valid_in = '0; step();

    // Flag accumulation
    reset = 1'b1; step(); reset = 1'b0;
    u_flg[0] = 5'b10000; valid_in = 6'b000001; step();
    u_flg[1] = 5'b00001; valid_in = 6'b000010; step();
    valid_in = '0; step();
    chk("acc_fflags", fflags, 5'b10001);
    u_flg[2] = 5'b00100; valid_in = 6'b000100; step();
    valid_in = '0; ready_in = 1'b0; step(); step();
    chk("held_no_acc", fflags, 5'b10001);

    // CSR write colliding with a retirement
    fflags_we = 1'b1; fflags_wdata = 5'b11111; step();
    chk("csr_set", fflags, 5'b11111);
    fflags_wdata = 5'b00000; ready_in = 1'b1; step();
    chk("csr_collide", fflags, 5'b00100);
    fflags_we = 1'b0;

    // Reset with a held result
    u_flg[0] = 5'b10000; valid_in = 6'b000001; step();
    valid_in = '0; ready_in = 1'b0; reset = 1'b1; step();
    chk("rst_mid_valid", valid_out, 1'b0);
    chk("rst_mid_fflags", fflags, 5'd0);
    reset = 1'b0; ready_in = 1'b1; valid_in = 6'b001001; step();
    chk("rst_ptr_zero", unit_out, 3'd0);
    valid_in = 6'b001000; step();
    chk("rst_then_u3", unit_out, 3'd3);
    valid_in = '0; step();

    // Randomized traffic; units hold data until accepted
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_in[i] || i == last_grant) begin
          valid_in[i] = ($urandom_range(0, 2) != 0);
          u_res[i] = $urandom;
          u_flg[i] = 5'($urandom_range(0, 31));
          u_rd[i]  = 5'($urandom_range(0, 31));
        end
      end
      ready_in     = ($urandom_range(0, 3) != 0);
      fflags_we    = ($urandom_range(0, 9) == 0);
      fflags_wdata = 5'($urandom_range(0, 31));
      reset        = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_result_arbiter.md
Name: fpu_result_arbiter

Overview:
Writeback-side collector for the FPU. It gathers results from N_UNITS functional units (min/max selector, comparator, converter, add/mul, div/sqrt, ...). Each unit delivers its result over a valid/ready handshake, and this block merges them into one registered result stream toward the integer/FP register-file writeback. It also keeps the sticky fflags accumulator (NV, DZ, OF, UF, NX), which the CSR unit reads and writes.

Parameters:
N_UNITS, 6, number of functional-unit result ports (>=2)
IDX_W, $clog2(N_UNITS), width of unit index

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  N_UNITS  per-unit result valid
ready_out  out  N_UNITS  per-unit accept; a unit retires on valid_in[i] && ready_out[i]
result_in  in  32*N_UNITS  per-unit result, unit i at [32*i+:32]
flags_in  in  5*N_UNITS  per-unit exception flags {NV,DZ,OF,UF,NX}, unit i at [5*i+:5]
rd_in  in  5*N_UNITS  per-unit destination register index
valid_out  out  1  merged result valid
ready_in  in  1  writeback accepts merged result
result_out  out  32  merged result
flags_out  out  5  flags of merged result
rd_out  out  5  destination of merged result
unit_out  out  IDX_W  index of unit that produced result_out
fflags_we  in  1  CSR write to fflags
fflags_wdata  in  5  CSR write data
fflags  out  5  sticky accumulated flags

Behaviour:
- Reset (clk edge with reset=1): valid_out=0, result_out=0, flags_out=0, rd_out=0, unit_out=0, rr_ptr=0, fflags=0. Reset overrides every other event, including a pending output or a CSR write.
- Output slot: single register stage; can_load = !valid_out || ready_in.
- Arbitration (combinational): round-robin over valid_in. Search starts at rr_ptr and wraps modulo N_UNITS. The first asserted index is grant g.
- ready_out[i] = can_load && any_valid && (i == g). At most one bit is set; all are 0 when can_load=0.
- Load: if can_load && any_valid, on the next edge:
  - valid_out=1; result_out, flags_out, rd_out load from unit g; unit_out=g.
  - rr_ptr = (g==N_UNITS-1) ? 0 : g+1.
- Drain: if valid_out && ready_in && !any_valid, valid_out=0 and the data registers clear to 0.
- Back-to-back: if valid_out && ready_in && any_valid, the slot is replaced in the same edge, giving 1 result/cycle sustained.
- Hold: if valid_out && !ready_in, all outputs are stable and rr_ptr is unchanged.
- Latency: 1 cycle from unit handshake to valid_out.
- Outputs are registered. ready_out depends combinationally on valid_in and ready_in. No combinational path from valid_in to valid_out.
- A unit whose valid_in drops without handshake is simply skipped. Units must hold data while valid_in && !ready_out.
- fflags accumulator. Retire event r = valid_out && ready_in. Next value:
  - fflags_we=1: fflags = fflags_wdata | (r ? flags_out : 0). A flag retiring in the same cycle is not lost.
  - else if r: fflags = fflags | flags_out.
  - else: unchanged.
- Flags accumulate on writeback retirement, not on unit acceptance, so a result flushed by reset never sets fflags.

Decomposition:
- FPU_pkg additions: FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0.
- FPU_pkg additions: typedef fpu_result_t {result[31:0], flags[4:0], rd[4:0]}.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; outputs grant_idx, any). Purely combinational; reusable for the FPU issue side.

Test Plan:
- Single unit: valid_in=6'b000001, result 0x3f800000, flags 0, rd 5, ready_in=1 -> next cycle valid_out=1, result_out=0x3f800000, rd_out=5, unit_out=0; ready_out[0] was 1 during the request.
- Contention: units 1, 3, 4 continuously valid, rr_ptr=0, ready_in=1 -> unit_out sequence 1,3,4,1,3,4; exactly one ready_out bit per cycle.
- Backpressure: load result from unit 2, hold ready_in=0 for 4 cycles while unit 5 is valid -> ready_out=0, outputs stable for 4 cycles. ready_in=1 -> unit 5 loads on the following edge with no bubble.
- Flag accumulation: retire unit 0 with flags 5'b10000, then unit 1 with 5'b00001 -> fflags=5'b10001. A result held without ready_in does not change fflags.
- CSR collision: fflags=5'b11111, fflags_we=1, fflags_wdata=0 in the same cycle a result with flags 5'b00100 retires -> fflags=5'b00100.
- Reset mid-operation: valid_out=1 with flags 5'b10000, ready_in=0, reset=1 for 1 cycle -> valid_out=0, fflags=0, rr_ptr=0; the next request from unit 3 is granted normally.
